bridge_fanout_decoder: RTL and testbench

//  Parametrised fan-out of one APF bridge master to NUM_LEAVES leaf bridges, generalising the single-leaf tree connection.

---
 rtl/bridge_fanout_decoder_pkg.sv | 25 ++
 rtl/bridge_addr_match.sv | 37 +++
 rtl/bridge_fanout_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_bridge_fanout_decoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_fanout_decoder_pkg.sv
// Shared types and constants for the bridge fan-out decoder and its address matcher.
package bridge_fanout_decoder_pkg;

    // Bridge bus widths as seen by the core bridge endpoint.
    localparam int BRIDGE_ADDR_W = 32;
    localparam int BRIDGE_DATA_W = 32;

    typedef logic [BRIDGE_ADDR_W-1:0] bridge_addr_t;
    typedef logic [BRIDGE_DATA_W-1:0] bridge_data_t;

    // Upper bound on leaves; leaf indices fit in four bits.
    localparam int BRIDGE_MAX_LEAVES = 16;
    typedef logic [3:0] leaf_idx_t;

    // Read latency counter width (latencies 1..255).
    localparam int RD_CNT_W = 8;
    typedef logic [RD_CNT_W-1:0] rd_cnt_t;

    // Read collection state.
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_WAIT = 1'b1
    } rd_state_e;

endpackage

// File: rtl/bridge_addr_match.sv
// Combinational base/mask window compare across all leaves, followed by a
// priority encoder so that the lowest-index matching leaf wins.
module bridge_addr_match
    import bridge_fanout_decoder_pkg::*;
#(
    parameter int                           NUM_LEAVES = 4,
    parameter int                           ADDR_W     = 32,
    parameter logic [NUM_LEAVES*ADDR_W-1:0] LEAF_BASE  = {NUM_LEAVES{32'h0}},
    parameter logic [NUM_LEAVES*ADDR_W-1:0] LEAF_MASK  = {NUM_LEAVES{32'hFFFF_0000}}
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output leaf_idx_t         idx
);

    logic [NUM_LEAVES-1:0] hit_vec;

    // One window comparator per leaf.
    generate
        for (genvar gi = 0; gi < NUM_LEAVES; gi++) begin : g_cmp
            assign hit_vec[gi] =
                ((addr & LEAF_MASK[gi*ADDR_W +: ADDR_W]) == LEAF_BASE[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Priority encode: scan from the top so the lowest matching index is left standing.
    always_comb begin
        hit = |hit_vec;
        idx = '0;
        for (int i = NUM_LEAVES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                idx = leaf_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/bridge_fanout_decoder.sv
// Fans one bridge master out to NUM_LEAVES leaf bridges. The request is
// optionally registered, decoded against per-leaf windows, and only the
// winning leaf sees a strobe. Reads are collected after the leaf's fixed
// latency and held on up_rd_data; unmapped reads return DEFAULT_RD_DATA.
module bridge_fanout_decoder
    import bridge_fanout_decoder_pkg::*;
#(
    parameter int                           NUM_LEAVES      = 4,
    parameter int                           ADDR_W          = 32,
    parameter int                           DATA_W          = 32,
    parameter logic [NUM_LEAVES*ADDR_W-1:0] LEAF_BASE       = {NUM_LEAVES{32'h0}},
    parameter logic [NUM_LEAVES*ADDR_W-1:0] LEAF_MASK       = {NUM_LEAVES{32'hFFFF_0000}},
    parameter logic [NUM_LEAVES*8-1:0]      LEAF_RD_LAT     = {NUM_LEAVES{8'd1}},
    parameter int                           REG_REQ         = 1,
    parameter logic [DATA_W-1:0]            DEFAULT_RD_DATA = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDR_W-1:0]            up_addr,
    input  logic [DATA_W-1:0]            up_wr_data,
    input  logic                         up_wr,
    input  logic                         up_rd,
    output logic [DATA_W-1:0]            up_rd_data,
    output logic [NUM_LEAVES*ADDR_W-1:0] leaf_addr,
    output logic [NUM_LEAVES*DATA_W-1:0] leaf_wr_data,
    output logic [NUM_LEAVES-1:0]        leaf_wr,
    output logic [NUM_LEAVES-1:0]        leaf_rd,
    input  logic [NUM_LEAVES*DATA_W-1:0] leaf_rd_data,
    output logic                         rd_busy,
    output logic                         err_collision,
    output logic                         err_unmapped
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    generate
        if (NUM_LEAVES < 1 || NUM_LEAVES > BRIDGE_MAX_LEAVES) begin : g_bad_num
            $error("bridge_fanout_decoder: NUM_LEAVES must be 1..%0d", BRIDGE_MAX_LEAVES);
        end
        for (genvar gi = 0; gi < NUM_LEAVES; gi++) begin : g_lat_chk
            if (LEAF_RD_LAT[gi*8 +: 8] == 8'd0) begin : g_bad_lat
                $error("bridge_fanout_decoder: LEAF_RD_LAT of leaf %0d is zero", gi);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Request stage: registered or straight through
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wr_data;
    logic              req_wr;
    logic              req_rd;

    generate
        if (REG_REQ != 0) begin : g_req_reg
            logic [ADDR_W-1:0] req_addr_q, req_addr_d;
            logic [DATA_W-1:0] req_wr_data_q, req_wr_data_d;
            logic              req_wr_q, req_wr_d;
            logic              req_rd_q, req_rd_d;

            // Capture the host request for presentation one clock later.
            always_comb begin
                req_addr_d    = up_addr;
                req_wr_data_d = up_wr_data;
                req_wr_d      = up_wr;
                req_rd_d      = up_rd;
            end

            // Request register; reset drops any request in the stage.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    req_addr_q    <= '0;
                    req_wr_data_q <= '0;
                    req_wr_q      <= 1'b0;
                    req_rd_q      <= 1'b0;
                end else begin
                    req_addr_q    <= req_addr_d;
                    req_wr_data_q <= req_wr_data_d;
                    req_wr_q      <= req_wr_d;
                    req_rd_q      <= req_rd_d;
                end
            end

            assign req_addr    = req_addr_q;
            assign req_wr_data = req_wr_data_q;
            assign req_wr      = req_wr_q;
            assign req_rd      = req_rd_q;
        end else begin : g_req_comb
            // Strobes are masked while reset is held so leaves see nothing.
            assign req_addr    = up_addr;
            assign req_wr_data = up_wr_data;
            assign req_wr      = up_wr & reset_n;
            assign req_rd      = up_rd & reset_n;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic      hit;
    leaf_idx_t hit_idx;

    bridge_addr_match #(
        .NUM_LEAVES (NUM_LEAVES),
        .ADDR_W     (ADDR_W),
        .LEAF_BASE  (LEAF_BASE),
        .LEAF_MASK  (LEAF_MASK)
    ) u_match (
        .addr (req_addr),
        .hit  (hit),
        .idx  (hit_idx)
    );

    // A collision keeps the write and drops the read.
    logic eff_rd;
    logic collision;
    logic access;

    assign eff_rd    = req_rd & ~req_wr;
    assign collision = req_wr & req_rd;
    assign access    = req_wr | req_rd;

    // ------------------------------------------------------------------
    // Broadcast and strobe demux
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LEAVES; gi++) begin : g_leaf
            assign leaf_addr[gi*ADDR_W +: ADDR_W]    = req_addr;
            assign leaf_wr_data[gi*DATA_W +: DATA_W] = req_wr_data;
            assign leaf_wr[gi] = req_wr & hit & (hit_idx == leaf_idx_t'(gi));
            assign leaf_rd[gi] = eff_rd & hit & (hit_idx == leaf_idx_t'(gi));
        end
    endgenerate

    // Per-leaf latency and read data padded out to the full index range,
    // so a 4-bit index never selects past the end.
    rd_cnt_t           lat_tbl   [BRIDGE_MAX_LEAVES];
    logic [DATA_W-1:0] rdata_tbl [BRIDGE_MAX_LEAVES];

    generate
        for (genvar gi = 0; gi < BRIDGE_MAX_LEAVES; gi++) begin : g_tbl
            if (gi < NUM_LEAVES) begin : g_real
                assign lat_tbl[gi]   = LEAF_RD_LAT[gi*8 +: 8];
                assign rdata_tbl[gi] = leaf_rd_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign lat_tbl[gi]   = rd_cnt_t'(1);
                assign rdata_tbl[gi] = '0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read FSM, data capture, sticky errors
    // ------------------------------------------------------------------
    rd_state_e         state_q, state_d;
    leaf_idx_t         sel_q, sel_d;
    rd_cnt_t           cnt_q, cnt_d;
    logic [DATA_W-1:0] up_rd_data_q, up_rd_data_d;
    logic              err_coll_q, err_coll_d;
    logic              err_unmap_q, err_unmap_d;

    // Next-state: count down the in-flight read, let a new read replace it,
    // and accumulate error flags.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        up_rd_data_d = up_rd_data_q;
        err_coll_d   = err_coll_q;
        err_unmap_d  = err_unmap_q;

        if (state_q == RD_WAIT) begin
            if (cnt_q == rd_cnt_t'(1)) begin
                up_rd_data_d = rdata_tbl[sel_q];
                state_d      = RD_IDLE;
            end else begin
                cnt_d = cnt_q - rd_cnt_t'(1);
            end
        end

        // Latest read wins: an old read finishing in the same clock is discarded.
        if (eff_rd) begin
            up_rd_data_d = up_rd_data_q;
            if (hit) begin
                state_d = RD_WAIT;
                sel_d   = hit_idx;
                cnt_d   = lat_tbl[hit_idx];
            end else begin
                state_d      = RD_IDLE;
                up_rd_data_d = DEFAULT_RD_DATA;
            end
        end

        if (collision) begin
            err_coll_d = 1'b1;
        end
        if (access && !hit) begin
            err_unmap_d = 1'b1;
        end
    end

    // State registers; reset abandons any read in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= RD_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            up_rd_data_q <= '0;
            err_coll_q   <= 1'b0;
            err_unmap_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            up_rd_data_q <= up_rd_data_d;
            err_coll_q   <= err_coll_d;
            err_unmap_q  <= err_unmap_d;
        end
    end

    // Busy covers the issue clock as well as the wait.
    assign rd_busy       = (state_q == RD_WAIT) | eff_rd;
    assign up_rd_data    = up_rd_data_q;
    assign err_collision = err_coll_q;
    assign err_unmapped  = err_unmap_q;

endmodule

// File: tb/tb_bridge_fanout_decoder.sv
// Randomised scoreboard bench for bridge_fanout_decoder. Leaf i returns a
// value that encodes its index and the current cycle, so a capture made on
// the wrong clock or from the wrong leaf shows up as a data difference.
module tb_bridge_fanout_decoder;

    localparam int NL   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXC = 8192;

    localparam logic [NL*AW-1:0] BASES = {32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NL*AW-1:0] MASKS = {32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    localparam logic [NL*8-1:0]  LATS  = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [DW-1:0]    DEFV  = 32'hDEAD_BEEF;

    // Reference view of the leaf map (leaf3 overlaps leaf2 for 0x0002_xxxx).
    logic [31:0] m_base [NL] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000};
    logic [31:0] m_mask [NL] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFE_0000};
    int          m_lat  [NL] = '{1, 2, 3, 4};

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [AW-1:0]     up_addr = '0;
    logic [DW-1:0]     up_wr_data = '0;
    logic              up_wr = 1'b0;
    logic              up_rd = 1'b0;
    logic [DW-1:0]     up_rd_data;
    logic [NL*AW-1:0]  leaf_addr;
    logic [NL*DW-1:0]  leaf_wr_data;
    logic [NL-1:0]     leaf_wr;
    logic [NL-1:0]     leaf_rd;
    logic [NL*DW-1:0]  leaf_rd_data;
    logic              rd_busy;
    logic              err_collision;
    logic              err_unmapped;

    bridge_fanout_decoder #(
        .NUM_LEAVES      (NL),
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .LEAF_BASE       (BASES),
        .LEAF_MASK       (MASKS),
        .LEAF_RD_LAT     (LATS),
        .REG_REQ         (1),
        .DEFAULT_RD_DATA (DEFV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .up_addr       (up_addr),
        .up_wr_data    (up_wr_data),
        .up_wr         (up_wr),
        .up_rd         (up_rd),
        .up_rd_data    (up_rd_data),
        .leaf_addr     (leaf_addr),
        .leaf_wr_data  (leaf_wr_data),
        .leaf_wr       (leaf_wr),
        .leaf_rd       (leaf_rd),
        .leaf_rd_data  (leaf_rd_data),
        .rd_busy       (rd_busy),
        .err_collision (err_collision),
        .err_unmapped  (err_unmapped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Leaf model: data depends on leaf index and cycle.
    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_leaf
            assign leaf_rd_data[gi*DW +: DW] = {4'hA, 4'(gi), cyc[23:0]};
        end
    endgenerate

    typedef struct packed {
        int          cyc;
        logic [3:0]  wr;
        logic [3:0]  rd;
        logic [31:0] addr;
        logic [31:0] data;
    } strobe_t;

    typedef struct packed {
        int          cyc;
        logic [31:0] data;
    } rdres_t;

    strobe_t sq[$];
    rdres_t  rq[$];
    bit      busy_exp [MAXC];
    bit      errc_exp [MAXC];
    bit      erru_exp [MAXC];

    // Outstanding read that a later read may still cancel.
    bit          pend_v = 1'b0;
    int          pend_d = 0;
    logic [31:0] pend_data = '0;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NL; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] leaf_val(input int i, input int m);
        logic [31:0] iv;
        logic [31:0] mv;
        iv = i;
        mv = m;
        return {4'hA, iv[3:0], mv[23:0]};
    endfunction

    // A read becomes final once no later read can cancel it.
    task automatic finalize(input int limit);
        if (pend_v && pend_d <= limit) begin
            rq.push_back('{cyc: pend_d, data: pend_data});
            pend_v = 1'b0;
        end
    endtask

    task automatic set_busy(input int k, input int endc);
        for (int m = k + 1; m < k + 300 && m < MAXC; m++) busy_exp[m] = (m <= endc);
    endtask

    // One host cycle: model the effect, then drive it.
    task automatic do_op(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
        int k;
        int li;
        k  = cyc;
        li = decode(addr);
        finalize(k + 1);
        if (wr || rd) begin
            if (li < 0) for (int m = k + 2; m < MAXC; m++) erru_exp[m] = 1'b1;
            if (wr && rd) for (int m = k + 2; m < MAXC; m++) errc_exp[m] = 1'b1;
            if (wr && li >= 0)
                sq.push_back('{cyc: k + 1, wr: 4'(1 << li), rd: 4'h0, addr: addr, data: data});
            if (rd && !wr) begin
                pend_v = 1'b1;
                if (li >= 0) begin
                    sq.push_back('{cyc: k + 1, wr: 4'h0, rd: 4'(1 << li), addr: addr, data: data});
                    pend_d    = k + 2 + m_lat[li];
                    pend_data = leaf_val(li, k + 1 + m_lat[li]);
                    set_busy(k, k + 1 + m_lat[li]);
                end else begin
                    pend_d    = k + 2;
                    pend_data = DEFV;
                    set_busy(k, k + 1);
                end
            end
        end
        up_addr    = addr;
        up_wr_data = data;
        up_wr      = wr;
        up_rd      = rd;
        @(posedge clk);
        #1;
        up_wr = 1'b0;
        up_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_op(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // One-clock reset pulse: drops reads not yet captured and clears flags.
    task automatic do_reset();
        int k;
        k = cyc;
        finalize(k);
        pend_v = 1'b0;
        rq.push_back('{cyc: k + 1, data: 32'h0});
        for (int m = k + 1; m < MAXC; m++) begin
            busy_exp[m] = 1'b0;
            errc_exp[m] = 1'b0;
            erru_exp[m] = 1'b0;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        logic [31:0] lo;
        int          s;
        r  = $urandom();
        lo = $urandom();
        s  = $urandom_range(0, 5);
        if (s <= 3)      return {16'(s), lo[15:0]};
        else if (s == 4) return {16'h0009, lo[15:0]};
        else             return {r[31:16], lo[15:0]};
    endfunction

    // Monitor: pops expected strobes and read results as the DUT presents them.
    strobe_t     s_cur;
    rdres_t      r_cur;
    logic [31:0] prev_rd = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                s_cur = sq.pop_front();
                chk("strobe_missing", 32'(s_cur.wr | s_cur.rd), 32'h0);
            end
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                s_cur = sq.pop_front();
                chk("leaf_wr", 32'(leaf_wr), 32'(s_cur.wr));
                chk("leaf_rd", 32'(leaf_rd), 32'(s_cur.rd));
                for (int i = 0; i < NL; i++) begin
                    chk("leaf_addr", leaf_addr[i*AW +: AW], s_cur.addr);
                    chk("leaf_wr_data", leaf_wr_data[i*DW +: DW], s_cur.data);
                end
                $display("cycle %0d strobe wr=%b rd=%b addr=%h data=%h", cyc, leaf_wr, leaf_rd,
                         leaf_addr[AW-1:0], leaf_wr_data[DW-1:0]);
            end else begin
                chk("no_strobe", 32'(leaf_wr | leaf_rd), 32'h0);
            end

            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                r_cur = rq.pop_front();
                chk("rd_result_missed", 32'(r_cur.cyc), 32'(cyc));
            end
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                r_cur = rq.pop_front();
                chk("up_rd_data", up_rd_data, r_cur.data);
                $display("cycle %0d read result %h", cyc, up_rd_data);
            end else begin
                chk("up_rd_data_hold", up_rd_data, prev_rd);
            end
            prev_rd = up_rd_data;

            chk("rd_busy", 32'(rd_busy), 32'(busy_exp[cyc]));
            chk("err_collision", 32'(err_collision), 32'(errc_exp[cyc]));
            chk("err_unmapped", 32'(err_unmapped), 32'(erru_exp[cyc]));
        end
    end

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_up_rd_data", up_rd_data, 32'h0);
        chk("reset_leaf_wr", 32'(leaf_wr), 32'h0);
        chk("reset_leaf_rd", 32'(leaf_rd), 32'h0);
        chk("reset_rd_busy", 32'(rd_busy), 32'h0);
        chk("reset_err_collision", 32'(err_collision), 32'h0);
        chk("reset_err_unmapped", 32'(err_unmapped), 32'h0);
        chk("reset_leaf_addr0", leaf_addr[AW-1:0], 32'h0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Directed cases.
        do_op(1'b0, 1'b1, 32'h0002_0010, 32'h0);          // leaf2, latency 3
        idle(6);
        do_op(1'b1, 1'b0, 32'h0001_0004, 32'h0000_1234);  // write leaf1
        idle(2);
        do_op(1'b0, 1'b1, 32'h0009_0000, 32'h0);          // unmapped read
        idle(3);
        do_op(1'b0, 1'b1, 32'h0003_0000, 32'h0);          // leaf3 ...
        idle(1);
        do_op(1'b0, 1'b1, 32'h0000_0040, 32'h0);          // ... overtaken by leaf0
        idle(6);
        do_op(1'b1, 1'b1, 32'h0001_0008, 32'h5555_AAAA);  // collision
        idle(2);
        do_op(1'b0, 1'b1, 32'h0003_0010, 32'h0);          // read then reset mid-wait
        idle(2);
        do_reset();
        idle(8);
        do_op(1'b0, 1'b1, 32'h0000_0100, 32'h0);          // leaf0
        do_op(1'b1, 1'b0, 32'h0002_0100, 32'h0BAD_F00D);  // overlap: leaf2 wins over leaf3
        idle(6);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      idle(1);
            else if (r < 65) do_op(1'b0, 1'b1, rand_addr(), $urandom());
            else if (r < 88) do_op(1'b1, 1'b0, rand_addr(), $urandom());
            else if (r < 97) do_op(1'b1, 1'b1, rand_addr(), $urandom());
            else             do_reset();
        end

        finalize(MAXC);
        idle(20);
        chk("strobe_queue_drained", 32'(sq.size()), 32'h0);
        chk("read_queue_drained", 32'(rq.size()), 32'h0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
